clarvi_load_align: RTL and testbench

CLARVI_LOAD_ALIGN -- requirements
Module: clarvi_load_align

---
 rtl/clarvi_load_align.sv | 158 +++++++++++++++
 tb/tb_clarvi_load_align.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clarvi_load_align.sv
`default_nettype none
// ============================================================================
//  Module   : clarvi_load_align
//  Purpose  : Load-result buffer for the data-memory read path. Records
//             width / sign / byte offset / destination of each issued load,
//             accepts in-order read responses, aligns and extends the data,
//             and presents results to writeback with valid/ready handshake.
//  Ports    : clock, reset                    - clock, async active-high reset
//             issue_read, issue_width,
//             issue_unsigned, issue_offset,
//             issue_rd                        - load issue from the pipeline
//             mem_read_valid, mem_read_data   - in-order memory responses
//             wb_valid, wb_ready, wb_rd,
//             wb_data                         - writeback handshake / result
//             stall_for_memory_pending        - buffer full, do not issue
//             protocol_error                  - sticky protocol-violation flag
//  Revision : 1.0 - initial release
// ============================================================================

package clarvi_load_align_pkg;
    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2,
        MEM_D = 2'd3
    } mem_width_t;
endpackage

module clarvi_load_align
    import clarvi_load_align_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_read,
    input  mem_width_t  issue_width,
    input  logic        issue_unsigned,
    input  logic [2:0]  issue_offset,
    input  logic [4:0]  issue_rd,
    input  logic        mem_read_valid,
    input  logic [63:0] mem_read_data,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_data,
    output logic        stall_for_memory_pending,
    output logic        protocol_error
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] C_FULL = OCC_W'(DEPTH);

    // Entry control bits (reset) and payload (no reset needed)
    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_filled;
    mem_width_t        r_width    [DEPTH];
    logic [DEPTH-1:0]  r_unsigned;
    logic [2:0]        r_offset   [DEPTH];
    logic [4:0]        r_rd       [DEPTH];
    logic [63:0]       r_data     [DEPTH];

    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_fill;
    logic [PTR_W-1:0]  r_tail;
    logic [OCC_W-1:0]  r_occ;
    logic              r_protocol_error;

    logic              w_full;
    logic              w_push;
    logic              w_fill;
    logic              w_pop;
    logic [63:0]       w_shifted;
    logic [63:0]       w_aligned;

    assign w_full = (r_occ == C_FULL);
    // A full buffer drops the issue even if the head pops this cycle.
    assign w_push = issue_read && !w_full;
    // The fill pointer always sits on the oldest unfilled entry (or on the
    // tail when none exists), so one lookup decides whether a response fits.
    assign w_fill = mem_read_valid && r_valid[r_fill] && !r_filled[r_fill];
    assign w_pop  = wb_valid && wb_ready;

    // Align the returned word for the entry being filled.
    always_comb begin
        w_shifted = mem_read_data >> {r_offset[r_fill], 3'b000};
        w_aligned = w_shifted;
        case (r_width[r_fill])
            MEM_B:   w_aligned = r_unsigned[r_fill] ? {56'd0, w_shifted[7:0]}
                                                    : {{56{w_shifted[7]}}, w_shifted[7:0]};
            MEM_H:   w_aligned = r_unsigned[r_fill] ? {48'd0, w_shifted[15:0]}
                                                    : {{48{w_shifted[15]}}, w_shifted[15:0]};
            MEM_W:   w_aligned = r_unsigned[r_fill] ? {32'd0, w_shifted[31:0]}
                                                    : {{32{w_shifted[31]}}, w_shifted[31:0]};
            default: w_aligned = w_shifted;  // D: full word, sign bit irrelevant
        endcase
    end

    // Control state: pointers, occupancy, valid/filled flags, error flag.
    // Push, fill and pop never touch the same entry in one cycle: push uses
    // an invalid slot, fill an unfilled valid one, pop a filled one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid          <= '0;
            r_filled         <= '0;
            r_head           <= '0;
            r_fill           <= '0;
            r_tail           <= '0;
            r_occ            <= '0;
            r_protocol_error <= 1'b0;
        end else begin
            if (w_push) begin
                r_valid[r_tail]  <= 1'b1;
                r_filled[r_tail] <= 1'b0;
                r_tail           <= r_tail + PTR_W'(1);
            end
            if (w_fill) begin
                r_filled[r_fill] <= 1'b1;
                r_fill           <= r_fill + PTR_W'(1);
            end
            if (w_pop) begin
                r_valid[r_head]  <= 1'b0;
                r_filled[r_head] <= 1'b0;
                r_head           <= r_head + PTR_W'(1);
            end
            if ((issue_read && w_full) || (mem_read_valid && !w_fill)) begin
                r_protocol_error <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Payload storage
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_width[r_tail]    <= issue_width;
            r_unsigned[r_tail] <= issue_unsigned;
            r_offset[r_tail]   <= issue_offset;
            r_rd[r_tail]       <= issue_rd;
        end
        if (w_fill) begin
            r_data[r_fill] <= w_aligned;
        end
    end

    assign wb_valid                 = r_valid[r_head] && r_filled[r_head];
    assign wb_rd                    = r_rd[r_head];
    assign wb_data                  = r_data[r_head];
    assign stall_for_memory_pending = w_full;
    assign protocol_error           = r_protocol_error;

endmodule
`default_nettype wire

// File: tb/tb_clarvi_load_align.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clarvi_load_align
//  Purpose  : Self-checking bench for clarvi_load_align: fixed single-load
//             vectors, hand-written multi-cycle corner sequences and a
//             randomized run against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clarvi_load_align;
    import clarvi_load_align_pkg::*;

    localparam int DEPTH = 2;

    logic        clock;
    logic        reset;
    logic        issue_read;
    mem_width_t  issue_width;
    logic        issue_unsigned;
    logic [2:0]  issue_offset;
    logic [4:0]  issue_rd;
    logic        mem_read_valid;
    logic [63:0] mem_read_data;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        stall_for_memory_pending;
    logic        protocol_error;

    int n_checks = 0;
    int n_errors = 0;

    clarvi_load_align #(.DEPTH(DEPTH)) dut (
        .clock                    (clock),
        .reset                    (reset),
        .issue_read               (issue_read),
        .issue_width              (issue_width),
        .issue_unsigned           (issue_unsigned),
        .issue_offset             (issue_offset),
        .issue_rd                 (issue_rd),
        .mem_read_valid           (mem_read_valid),
        .mem_read_data            (mem_read_data),
        .wb_valid                 (wb_valid),
        .wb_ready                 (wb_ready),
        .wb_rd                    (wb_rd),
        .wb_data                  (wb_data),
        .stall_for_memory_pending (stall_for_memory_pending),
        .protocol_error           (protocol_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        mem_width_t  w;
        logic        u;
        logic [2:0]  off;
        logic [4:0]  rd;
        logic [63:0] resp;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        mem_width_t  w;
        logic        u;
        logic [2:0]  off;
    } load_t;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } res_t;

    vec_t  vecs [8];
    load_t pend [$];
    res_t  done [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic set_issue(input logic v, input mem_width_t w, input logic u,
                             input logic [2:0] off, input logic [4:0] rd);
        issue_read     = v;
        issue_width    = w;
        issue_unsigned = u;
        issue_offset   = off;
        issue_rd       = rd;
    endtask

    // Reference alignment from the arithmetic rules: shift right by whole
    // bytes, keep the low field, sign-extend unless unsigned or 64-bit.
    function automatic logic [63:0] ref_align(input mem_width_t w, input logic u,
                                              input logic [2:0] off, input logic [63:0] d);
        int          nbits;
        logic [63:0] s;
        logic [63:0] mask;
        logic [63:0] f;
        nbits = 8 << int'(w);
        s     = d >> (int'(off) * 8);
        mask  = (nbits == 64) ? {64{1'b1}} : ((64'd1 << nbits) - 64'd1);
        f     = s & mask;
        if (!u && nbits < 64 && f[nbits-1]) f = f | ~mask;
        return f;
    endfunction

    initial begin
        vecs[0] = '{MEM_B, 1'b0, 3'd3, 5'd5,  64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80};
        vecs[1] = '{MEM_B, 1'b1, 3'd3, 5'd6,  64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080};
        vecs[2] = '{MEM_W, 1'b0, 3'd4, 5'd7,  64'h1234_5678_0000_0000, 64'h0000_0000_1234_5678};
        vecs[3] = '{MEM_H, 1'b0, 3'd6, 5'd9,  64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001};
        vecs[4] = '{MEM_D, 1'b0, 3'd0, 5'd10, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001};
        vecs[5] = '{MEM_D, 1'b0, 3'd4, 5'd11, 64'hAABB_CCDD_1122_3344, 64'h0000_0000_AABB_CCDD};
        vecs[6] = '{MEM_W, 1'b0, 3'd6, 5'd12, 64'hFFFF_0000_0000_0000, 64'h0000_0000_0000_FFFF};
        vecs[7] = '{MEM_H, 1'b0, 3'd7, 5'd31, 64'h9900_0000_0000_0000, 64'h0000_0000_0000_0099};

        reset = 1'b1;
        set_issue(1'b0, MEM_B, 1'b0, 3'd0, 5'd0);
        mem_read_valid = 1'b0;
        mem_read_data  = '0;
        wb_ready       = 1'b0;
        #3;
        check("reset_wb_valid", 64'(wb_valid), 64'd0);
        check("reset_stall", 64'(stall_for_memory_pending), 64'd0);
        check("reset_perr", 64'(protocol_error), 64'd0);
        reset = 1'b0;
        tick();

        // ---------------- single-load vectors ----------------
        for (int i = 0; i < 8; i++) begin
            set_issue(1'b1, vecs[i].w, vecs[i].u, vecs[i].off, vecs[i].rd);
            tick();
            issue_read     = 1'b0;
            check($sformatf("vec%0d_wait_valid", i), 64'(wb_valid), 64'd0);
            mem_read_valid = 1'b1;
            mem_read_data  = vecs[i].resp;
            tick();
            mem_read_valid = 1'b0;
            check($sformatf("vec%0d_wb_valid", i), 64'(wb_valid), 64'd1);
            check($sformatf("vec%0d_wb_rd", i), 64'(wb_rd), 64'(vecs[i].rd));
            check($sformatf("vec%0d_wb_data", i), wb_data, vecs[i].exp);
            wb_ready = 1'b1;
            tick();
            wb_ready = 1'b0;
            check($sformatf("vec%0d_popped", i), 64'(wb_valid), 64'd0);
        end
        check("vec_perr", 64'(protocol_error), 64'd0);

        // ---------------- fill to full, overflow issue ----------------
        set_issue(1'b1, MEM_H, 1'b0, 3'd2, 5'd1);
        tick();
        check("one_out_stall", 64'(stall_for_memory_pending), 64'd0);
        set_issue(1'b1, MEM_D, 1'b0, 3'd0, 5'd2);
        tick();
        check("full_stall", 64'(stall_for_memory_pending), 64'd1);
        check("full_perr", 64'(protocol_error), 64'd0);
        set_issue(1'b1, MEM_B, 1'b0, 3'd0, 5'd3);
        tick();
        issue_read = 1'b0;
        check("overflow_perr", 64'(protocol_error), 64'd1);
        check("overflow_stall", 64'(stall_for_memory_pending), 64'd1);

        // ---------------- backpressure, then drain ----------------
        mem_read_valid = 1'b1;
        mem_read_data  = 64'h0000_0000_ABCD_0000;
        tick();
        mem_read_data  = 64'h0123_4567_89AB_CDEF;
        tick();
        mem_read_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold%0d_valid", i), 64'(wb_valid), 64'd1);
            check($sformatf("hold%0d_rd", i), 64'(wb_rd), 64'd1);
            check($sformatf("hold%0d_data", i), wb_data, 64'hFFFF_FFFF_FFFF_ABCD);
            tick();
        end
        wb_ready = 1'b1;
        tick();
        check("drain1_valid", 64'(wb_valid), 64'd1);
        check("drain1_rd", 64'(wb_rd), 64'd2);
        check("drain1_data", wb_data, 64'h0123_4567_89AB_CDEF);
        check("drain1_stall", 64'(stall_for_memory_pending), 64'd0);
        tick();
        wb_ready = 1'b0;
        check("drain2_valid", 64'(wb_valid), 64'd0);
        check("sticky_perr", 64'(protocol_error), 64'd1);

        // ---------------- full + pop + issue same cycle: issue dropped ----------------
        do_reset();
        check("rst_clear_perr", 64'(protocol_error), 64'd0);
        tick();
        set_issue(1'b1, MEM_W, 1'b1, 3'd0, 5'd20);
        tick();
        set_issue(1'b1, MEM_W, 1'b1, 3'd0, 5'd21);
        mem_read_valid = 1'b1;
        mem_read_data  = 64'h0000_0000_0000_0014;
        tick();
        issue_read     = 1'b0;
        mem_read_data  = 64'h0000_0000_0000_0015;
        tick();
        mem_read_valid = 1'b0;
        check("fp_stall", 64'(stall_for_memory_pending), 64'd1);
        set_issue(1'b1, MEM_W, 1'b1, 3'd0, 5'd22);
        wb_ready = 1'b1;
        tick();
        issue_read = 1'b0;
        check("fp_perr", 64'(protocol_error), 64'd1);
        check("fp_stall_after", 64'(stall_for_memory_pending), 64'd0);
        check("fp_rd", 64'(wb_rd), 64'd21);
        tick();
        wb_ready = 1'b0;
        check("fp_empty", 64'(wb_valid), 64'd0);

        // ---------------- response with empty buffer ----------------
        do_reset();
        tick();
        mem_read_valid = 1'b1;
        mem_read_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        mem_read_valid = 1'b0;
        check("empty_resp_perr", 64'(protocol_error), 64'd1);
        check("empty_resp_valid", 64'(wb_valid), 64'd0);

        // ---------------- asynchronous reset mid-operation ----------------
        do_reset();
        tick();
        set_issue(1'b1, MEM_D, 1'b0, 3'd0, 5'd4);
        tick();
        set_issue(1'b1, MEM_D, 1'b0, 3'd0, 5'd5);
        mem_read_valid = 1'b1;
        mem_read_data  = 64'h1111_2222_3333_4444;
        tick();
        issue_read     = 1'b0;
        mem_read_valid = 1'b0;
        check("pre_rst_valid", 64'(wb_valid), 64'd1);
        check("pre_rst_stall", 64'(stall_for_memory_pending), 64'd1);
        reset = 1'b1;
        #1;
        check("async_rst_valid", 64'(wb_valid), 64'd0);
        check("async_rst_stall", 64'(stall_for_memory_pending), 64'd0);
        reset = 1'b0;
        tick();
        mem_read_valid = 1'b1;
        mem_read_data  = 64'h5555_6666_7777_8888;
        tick();
        mem_read_valid = 1'b0;
        check("stale_resp_perr", 64'(protocol_error), 64'd1);
        check("stale_resp_valid", 64'(wb_valid), 64'd0);

        // ---------------- randomized run vs. queue model ----------------
        do_reset();
        tick();
        pend.delete();
        done.delete();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            int    occ;
            logic  iss;
            logic  rsp;
            logic  rdy;
            load_t l;
            res_t  r;
            occ = pend.size() + done.size();
            iss = (occ < DEPTH) && ($urandom_range(0, 2) != 0);
            rsp = (pend.size() > 0) && ($urandom_range(0, 1) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            l.rd  = 5'($urandom_range(0, 31));
            l.w   = mem_width_t'($urandom_range(0, 3));
            l.u   = 1'($urandom_range(0, 1));
            l.off = 3'($urandom_range(0, 7));
            set_issue(iss, l.w, l.u, l.off, l.rd);
            mem_read_valid = rsp;
            mem_read_data  = {$urandom, $urandom};
            wb_ready       = rdy;
            if (done.size() > 0 && rdy) void'(done.pop_front());
            if (rsp) begin
                load_t p;
                p      = pend.pop_front();
                r.rd   = p.rd;
                r.data = ref_align(p.w, p.u, p.off, mem_read_data);
                done.push_back(r);
            end
            if (iss) pend.push_back(l);
            tick();
            check("rnd_wb_valid", 64'(wb_valid), 64'(done.size() > 0));
            check("rnd_stall", 64'(stall_for_memory_pending),
                  64'((pend.size() + done.size()) == DEPTH));
            if (done.size() > 0) begin
                check("rnd_wb_rd", 64'(wb_rd), 64'(done[0].rd));
                check("rnd_wb_data", wb_data, done[0].data);
            end
        end
        issue_read     = 1'b0;
        mem_read_valid = 1'b0;
        wb_ready       = 1'b0;
        check("rnd_perr", 64'(protocol_error), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
